// File: rtl/mcoi_led_driver_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcoi_led_driver_pkg
// Description : Shared types and helpers for the MCOI diagnostic LED driver.
// Revision    : 1.0 - initial release
// ============================================================================
package mcoi_led_driver_pkg;

    localparam int LED_MODE_W = 3;

    typedef enum logic [LED_MODE_W-1:0] {
        LED_OFF       = 3'd0,
        LED_ON        = 3'd1,
        LED_SLOW      = 3'd2,
        LED_FAST      = 3'd3,
        LED_FLASH     = 3'd4,
        LED_HEARTBEAT = 3'd5
    } led_mode_t;

    // Register width needed to hold n_states distinct values, never below 1.
    function automatic int width_for(input int n_states);
        return (n_states <= 2) ? 1 : $clog2(n_states);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcoi_tick_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcoi_tick_gen
// Description : Free-running prescaler; one-cycle tick every DIV clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module mcoi_tick_gen
    import mcoi_led_driver_pkg::*;
#(
    parameter int DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int                 c_CNT_W = width_for(DIV);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);

    // A divider below 2 cannot produce a one-cycle pulse with a gap.
    if (DIV < 2) begin : g_div_check
        $error("mcoi_tick_gen: DIV must be at least 2");
    end

    logic [c_CNT_W-1:0] r_cnt;

    // Count 0..DIV-1 and wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick_o = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/mcoi_led_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcoi_led_driver
// Description : Multi-channel diagnostic LED driver (off/on/slow/fast/flash/
//               heartbeat) with all channels sharing one tick and phase.
// Revision    : 1.0 - initial release
// ============================================================================
module mcoi_led_driver
    import mcoi_led_driver_pkg::*;
#(
    parameter int                  NUM_LEDS        = 6,
    parameter int                  CLK_FREQ_HZ     = 100_000_000,
    parameter int                  TICK_HZ         = 1000,
    parameter int                  SLOW_HALF_TICKS = 500,
    parameter int                  FAST_HALF_TICKS = 100,
    parameter int                  STRETCH_TICKS   = 50,
    parameter logic [NUM_LEDS-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [LED_MODE_W*NUM_LEDS-1:0] mode_i,
    input  logic [NUM_LEDS-1:0]            event_i,
    output logic [NUM_LEDS-1:0]            led_o,
    output logic                           tick_o
);

    localparam int c_DIV       = CLK_FREQ_HZ / TICK_HZ;
    localparam int c_SLOW_W    = width_for(SLOW_HALF_TICKS);
    localparam int c_FAST_W    = width_for(FAST_HALF_TICKS);
    localparam int c_HB_PERIOD = 10 * FAST_HALF_TICKS;
    localparam int c_HB_W      = width_for(c_HB_PERIOD);
    localparam int c_STR_W     = width_for(STRETCH_TICKS + 1);

    localparam logic [c_SLOW_W-1:0] c_SLOW_LAST = c_SLOW_W'(SLOW_HALF_TICKS - 1);
    localparam logic [c_FAST_W-1:0] c_FAST_LAST = c_FAST_W'(FAST_HALF_TICKS - 1);
    localparam logic [c_HB_W-1:0]   c_HB_LAST   = c_HB_W'(c_HB_PERIOD - 1);
    localparam logic [c_HB_W-1:0]   c_HB_F      = c_HB_W'(FAST_HALF_TICKS);
    localparam logic [c_HB_W-1:0]   c_HB_2F     = c_HB_W'(2 * FAST_HALF_TICKS);
    localparam logic [c_HB_W-1:0]   c_HB_3F     = c_HB_W'(3 * FAST_HALF_TICKS);
    localparam logic [c_STR_W-1:0]  c_STRETCH   = c_STR_W'(STRETCH_TICKS);

    logic                w_tick;
    logic [c_SLOW_W-1:0] r_slow_cnt, w_slow_cnt_nxt;
    logic                r_slow_ph,  w_slow_ph_nxt;
    logic [c_FAST_W-1:0] r_fast_cnt, w_fast_cnt_nxt;
    logic                r_fast_ph,  w_fast_ph_nxt;
    logic [c_HB_W-1:0]   r_hb_cnt,   w_hb_cnt_nxt;
    logic                w_hb_lit;
    logic [NUM_LEDS-1:0] w_lit;
    logic [NUM_LEDS-1:0] r_led;

    mcoi_tick_gen #(
        .DIV    (c_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .tick_o (w_tick)
    );

    // Shared blink/heartbeat next state. Channels display these next-state
    // values so an edge shows up one cycle after the tick that causes it,
    // and a mode change in the same cycle already sees the updated phase.
    always_comb begin
        w_slow_cnt_nxt = r_slow_cnt;
        w_slow_ph_nxt  = r_slow_ph;
        w_fast_cnt_nxt = r_fast_cnt;
        w_fast_ph_nxt  = r_fast_ph;
        w_hb_cnt_nxt   = r_hb_cnt;
        if (w_tick) begin
            if (r_slow_cnt == c_SLOW_LAST) begin
                w_slow_cnt_nxt = '0;
                w_slow_ph_nxt  = ~r_slow_ph;
            end else begin
                w_slow_cnt_nxt = r_slow_cnt + 1'b1;
            end
            if (r_fast_cnt == c_FAST_LAST) begin
                w_fast_cnt_nxt = '0;
                w_fast_ph_nxt  = ~r_fast_ph;
            end else begin
                w_fast_cnt_nxt = r_fast_cnt + 1'b1;
            end
            if (r_hb_cnt == c_HB_LAST) begin
                w_hb_cnt_nxt = '0;
            end else begin
                w_hb_cnt_nxt = r_hb_cnt + 1'b1;
            end
        end
    end

    // Two pulses per heartbeat period: [0,F) and [2F,3F).
    assign w_hb_lit = (w_hb_cnt_nxt < c_HB_F) ||
                      ((w_hb_cnt_nxt >= c_HB_2F) && (w_hb_cnt_nxt < c_HB_3F));

    // Shared blink and heartbeat state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slow_cnt <= '0;
            r_slow_ph  <= 1'b0;
            r_fast_cnt <= '0;
            r_fast_ph  <= 1'b0;
            r_hb_cnt   <= '0;
        end else begin
            r_slow_cnt <= w_slow_cnt_nxt;
            r_slow_ph  <= w_slow_ph_nxt;
            r_fast_cnt <= w_fast_cnt_nxt;
            r_fast_ph  <= w_fast_ph_nxt;
            r_hb_cnt   <= w_hb_cnt_nxt;
        end
    end

    for (genvar n = 0; n < NUM_LEDS; n++) begin : g_ch
        logic [LED_MODE_W-1:0] w_mode;
        logic [c_STR_W-1:0]    r_stretch;
        logic [c_STR_W-1:0]    w_stretch_nxt;
        logic                  w_ch_lit;

        assign w_mode = mode_i[LED_MODE_W*n +: LED_MODE_W];

        // Stretch counter runs in every mode; an event reloads it and wins
        // over a same-cycle decrement.
        always_comb begin
            w_stretch_nxt = r_stretch;
            if (event_i[n]) begin
                w_stretch_nxt = c_STRETCH;
            end else if (w_tick && (r_stretch != '0)) begin
                w_stretch_nxt = r_stretch - 1'b1;
            end
        end

        // Per-channel stretch counter register.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stretch <= '0;
            end else begin
                r_stretch <= w_stretch_nxt;
            end
        end

        // Mode select; unused codes fall through to dark.
        always_comb begin
            w_ch_lit = 1'b0;
            case (w_mode)
                LED_ON:        w_ch_lit = 1'b1;
                LED_SLOW:      w_ch_lit = w_slow_ph_nxt;
                LED_FAST:      w_ch_lit = w_fast_ph_nxt;
                LED_FLASH:     w_ch_lit = event_i[n] | (w_stretch_nxt != '0);
                LED_HEARTBEAT: w_ch_lit = w_hb_lit;
                default:       w_ch_lit = 1'b0;
            endcase
        end

        assign w_lit[n] = w_ch_lit;
    end

    // Registered LED drive with per-pin polarity; reset leaves all dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= ACTIVE_LOW_MASK;
        end else begin
            r_led <= w_lit ^ ACTIVE_LOW_MASK;
        end
    end

    assign led_o  = r_led;
    assign tick_o = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_mcoi_led_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mcoi_led_driver
// Description : Directed, table-driven bench for mcoi_led_driver
//               (DIV=10, SLOW=5, FAST=2, STRETCH=3, 4 LEDs, LED3 active-low).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcoi_led_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mode_i = '0;
    logic [3:0]  event_i = '0;
    logic [3:0]  led_o;
    logic        tick_o;

    int checks = 0;
    int errors = 0;
    int k = 0;

    typedef struct {
        int          k;
        logic [3:0]  led;
        logic        tick;
        logic [11:0] mode;
        logic [3:0]  ev;
    } vec_t;

    vec_t tbl[$];
    vec_t tbl2[$];

    mcoi_led_driver #(
        .NUM_LEDS        (4),
        .CLK_FREQ_HZ     (10_000),
        .TICK_HZ         (1000),
        .SLOW_HALF_TICKS (5),
        .FAST_HALF_TICKS (2),
        .STRETCH_TICKS   (3),
        .ACTIVE_LOW_MASK (4'b1000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode_i  (mode_i),
        .event_i (event_i),
        .led_o   (led_o),
        .tick_o  (tick_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] m(input logic [2:0] c3, input logic [2:0] c2,
                                      input logic [2:0] c1, input logic [2:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    task automatic add(input int kk, input logic [3:0] led, input logic tick,
                       input logic [11:0] md, input logic [3:0] ev);
        vec_t v;
        v.k = kk; v.led = led; v.tick = tick; v.mode = md; v.ev = ev;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int kk, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%b required=%b", name, kk, act, exp);
        end
    endtask

    task automatic advance_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog k=%0d actual=timeout required=finish", k);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // codes: 0 OFF 1 ON 2 SLOW 3 FAST 4 FLASH 5 HEARTBEAT
        // Scenario 1: all OFF, tick cadence
        add(  0, 4'b1000, 1'b0, m(0,0,0,0), 4'b0000);
        add(  8, 4'b1000, 1'b0, m(0,0,0,0), 4'b0000);
        add(  9, 4'b1000, 1'b1, m(0,0,0,0), 4'b0000);
        add( 10, 4'b1000, 1'b0, m(0,0,0,0), 4'b0000);
        add( 19, 4'b1000, 1'b1, m(0,3,2,1), 4'b0000);
        // Scenario 2: ON / SLOW / FAST
        add( 20, 4'b1101, 1'b0, m(0,3,2,1), 4'b0000);
        add( 39, 4'b1101, 1'b1, m(0,3,2,1), 4'b0000);
        add( 40, 4'b1001, 1'b0, m(0,3,2,1), 4'b0000);
        add( 49, 4'b1001, 1'b1, m(0,3,2,1), 4'b0000);
        add( 50, 4'b1011, 1'b0, m(0,3,2,1), 4'b0000);
        add( 60, 4'b1111, 1'b0, m(0,3,2,1), 4'b0000);
        add( 99, 4'b1011, 1'b1, m(0,3,2,1), 4'b0000);
        add(100, 4'b1101, 1'b0, m(4,3,2,1), 4'b1000);
        // Scenario 3: flash, then retrigger on a tick cycle
        add(101, 4'b0101, 1'b0, m(4,3,2,1), 4'b0000);
        add(129, 4'b0001, 1'b1, m(4,3,2,1), 4'b0000);
        add(130, 4'b1001, 1'b0, m(4,3,2,1), 4'b0000);
        add(140, 4'b1101, 1'b0, m(4,3,2,1), 4'b1000);
        add(141, 4'b0101, 1'b0, m(4,3,2,1), 4'b0000);
        add(159, 4'b0111, 1'b1, m(4,3,2,1), 4'b1000);
        add(160, 4'b0011, 1'b0, m(4,3,2,1), 4'b0000);
        add(170, 4'b0011, 1'b0, m(4,3,2,1), 4'b0000);
        add(189, 4'b0111, 1'b1, m(4,3,2,1), 4'b0000);
        add(190, 4'b1111, 1'b0, m(4,3,2,1), 4'b0000);
        add(199, 4'b1111, 1'b1, m(4,0,0,5), 4'b0000);
        // Scenario 4: heartbeat on ch0
        add(200, 4'b1001, 1'b0, m(4,0,0,5), 4'b0000);
        add(219, 4'b1001, 1'b1, m(4,0,0,5), 4'b0000);
        add(220, 4'b1000, 1'b0, m(4,0,0,5), 4'b0000);
        add(239, 4'b1000, 1'b1, m(4,0,0,5), 4'b0000);
        add(240, 4'b1001, 1'b0, m(4,0,0,5), 4'b0000);
        add(259, 4'b1001, 1'b1, m(4,0,0,5), 4'b0000);
        add(260, 4'b1000, 1'b0, m(4,0,0,5), 4'b0000);
        add(399, 4'b1000, 1'b1, m(4,0,0,5), 4'b0000);
        add(400, 4'b1001, 1'b0, m(4,0,0,5), 4'b0000);
        add(440, 4'b1001, 1'b0, m(4,0,0,5), 4'b0000);
        add(460, 4'b1000, 1'b0, m(4,0,0,5), 4'b0000);
        add(599, 4'b1000, 1'b1, m(4,0,0,5), 4'b0000);
        // Scenario 5: codes 6/7 while both blink phases are lit, pending stretch
        add(660, 4'b1000, 1'b0, m(4,0,6,0), 4'b0000);
        add(661, 4'b1000, 1'b0, m(4,0,7,0), 4'b0000);
        add(662, 4'b1000, 1'b0, m(4,0,7,0), 4'b0000);
        add(670, 4'b1000, 1'b0, m(4,0,0,0), 4'b0010);
        add(671, 4'b1000, 1'b0, m(4,0,0,0), 4'b0000);
        add(685, 4'b1000, 1'b0, m(4,0,4,0), 4'b0000);
        add(686, 4'b1010, 1'b0, m(4,0,4,0), 4'b0000);
        add(699, 4'b1010, 1'b1, m(4,0,4,0), 4'b0000);
        add(700, 4'b1000, 1'b0, m(4,3,0,0), 4'b0000);
        // Scenario 6 lead-in: mid-blink and mid-flash
        add(710, 4'b1100, 1'b0, m(4,3,0,0), 4'b1000);
        add(711, 4'b0100, 1'b0, m(4,3,0,0), 4'b0000);
        add(718, 4'b0100, 1'b0, m(4,3,0,0), 4'b0000);

        // Restart timing after the mid-run reset (modes stay FLASH/FAST)
        begin
            int rk[7]          = '{0, 9, 10, 19, 20, 39, 40};
            logic [3:0] rl[7]  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1000};
            logic       rt[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
            for (int i = 0; i < 7; i++) begin
                vec_t v;
                v.k = rk[i]; v.led = rl[i]; v.tick = rt[i];
                v.mode = m(4,3,0,0); v.ev = 4'b0000;
                tbl2.push_back(v);
            end
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        k = 0;

        foreach (tbl[i]) begin
            advance_to(tbl[i].k);
            chk("led", k, led_o, tbl[i].led);
            chk("tick", k, {3'b000, tick_o}, {3'b000, tbl[i].tick});
            mode_i  = tbl[i].mode;
            event_i = tbl[i].ev;
        end

        // Reset lands on the cycle that would otherwise carry a tick
        rst = 1'b1;
        @(negedge clk);
        chk("rst_led", k, led_o, 4'b1000);
        chk("rst_tick", k, {3'b000, tick_o}, 4'b0000);
        @(negedge clk);
        chk("rst_hold_led", k, led_o, 4'b1000);
        rst = 1'b0;
        k = 0;

        foreach (tbl2[i]) begin
            advance_to(tbl2[i].k);
            chk("restart_led", k, led_o, tbl2[i].led);
            chk("restart_tick", k, {3'b000, tick_o}, {3'b000, tbl2[i].tick});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
